// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package demux_pkg;

  typedef logic [1:0] sel_t;

  localparam int N_CH = 4;

  // One-hot decode of a channel select.
  function automatic logic [N_CH-1:0] sel_onehot(input sel_t sel);
    logic [N_CH-1:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready register slice with a load port and a drain port.
module stream_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             can_load
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  // A full slot can still load when the consumer takes the old word this cycle.
  assign can_load = !valid_reg || ready;
  assign valid    = valid_reg;
  assign data     = data_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1_4.sv
// Streaming 1-to-4 demultiplexer: each accepted word goes to the slot picked by in_sel.
module stream_demux_1_4
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  sel_t             in_sel,
  output logic [N_CH-1:0]  out_valid,
  input  logic [N_CH-1:0]  out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
);

  logic [N_CH-1:0]  can_load;
  logic [N_CH-1:0]  load_en;
  logic [WIDTH-1:0] slot_data [N_CH];

  // Readiness follows only the addressed channel, never in_valid.
  assign in_ready = rst && can_load[in_sel];
  assign load_en  = (in_valid && in_ready) ? sel_onehot(in_sel) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_slot
      stream_slot #(.WIDTH(WIDTH)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load_en[gi]),
        .load_data (in_data),
        .valid     (out_valid[gi]),
        .ready     (out_ready[gi]),
        .data      (slot_data[gi]),
        .can_load  (can_load[gi])
      );

      a_no_drop: assert property (@(posedge clk) disable iff (!rst)
        (out_valid[gi] && !out_ready[gi]) |=> out_valid[gi]);
    end
  endgenerate

  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

  a_one_load: assert property (@(posedge clk) disable iff (!rst) $onehot0(load_en));

  a_ready_known: assert property (@(posedge clk) disable iff (!rst)
    !$isunknown(in_sel) |-> !$isunknown(in_ready));

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed self-checking bench for stream_demux_1_4.
module tb_stream_demux_1_4;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;

  int compared = 0;
  int mismatched = 0;

  stream_demux_1_4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Protocol monitor: a valid slot may only empty through a consumer transfer.
  logic [3:0] prev_v, prev_r;
  logic       prev_rst;
  logic       have_prev = 1'b0;
  always @(negedge clk) begin
    if (have_prev && prev_rst && rst) begin
      for (int k = 0; k < 4; k++) begin
        if (prev_v[k] && !prev_r[k]) begin
          compared++;
          assert (out_valid[k] === 1'b1) else begin
            mismatched++;
            $error("FAIL hold_ch%0d observed=%b expected=1", k, out_valid[k]);
          end
        end
      end
      compared++;
      assert (!$isunknown(in_ready)) else begin
        mismatched++;
        $error("FAIL ready_known observed=%b expected=0/1", in_ready);
      end
    end
    prev_v    = out_valid;
    prev_r    = out_ready;
    prev_rst  = rst;
    have_prev = 1'b1;
  end

  logic [WIDTH-1:0] xval;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 2'd0; out_ready = 4'b0000;
    tick();
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_valid", {28'b0, out_valid}, 32'h0);
    check("rst_data0", {28'b0, out_data0}, 32'h0);

    // Single word to channel 0, then blocked second word.
    rst = 1'b1; in_valid = 1'b1; in_data = 4'ha; in_sel = 2'd0;
    #1 check("t1_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("t1_valid", {28'b0, out_valid}, 32'h1);
    check("t1_data0", {28'b0, out_data0}, 32'ha);
    in_valid = 1'b1; in_data = 4'hb; in_sel = 2'd0;
    #1 check("t1_blocked", {31'b0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("t1_keep0", {28'b0, out_data0}, 32'ha);
    out_ready = 4'b0001;
    tick();
    out_ready = 4'b0000;
    check("t1_drain", {28'b0, out_valid}, 32'h0);
    check("t1_hold_data", {28'b0, out_data0}, 32'ha);

    // Fill all four channels, then drain channel 2 only.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'(4'ha + i); in_sel = 2'(i);
      tick();
    end
    in_valid = 1'b0;
    check("t2_valid", {28'b0, out_valid}, 32'hf);
    check("t2_data0", {28'b0, out_data0}, 32'ha);
    check("t2_data1", {28'b0, out_data1}, 32'hb);
    check("t2_data2", {28'b0, out_data2}, 32'hc);
    check("t2_data3", {28'b0, out_data3}, 32'hd);
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    check("t2_drain2", {28'b0, out_valid}, 32'hb);

    // Channel 1 full with consumer ready: back-to-back words, no bubble.
    out_ready = 4'b0010;
    in_valid = 1'b1; in_sel = 2'd1;
    in_data = 4'h3;
    #1 check("t3_ready_3", {31'b0, in_ready}, 32'd1);
    tick();
    check("t3_data_3", {28'b0, out_data1}, 32'h3);
    in_data = 4'h5;
    #1 check("t3_ready_5", {31'b0, in_ready}, 32'd1);
    tick();
    check("t3_data_5", {28'b0, out_data1}, 32'h5);
    in_data = 4'h7;
    #1 check("t3_ready_7", {31'b0, in_ready}, 32'd1);
    tick();
    check("t3_data_7", {28'b0, out_data1}, 32'h7);
    check("t3_valid", {28'b0, out_valid}, 32'hb);
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    check("t3_drained", {28'b0, out_valid}, 32'h9);

    // Channel 3 stalled: word waits, then the producer moves on to channel 0.
    in_valid = 1'b1; in_data = 4'h6; in_sel = 2'd3;
    #1 check("t4_stall", {31'b0, in_ready}, 32'd0);
    tick();
    check("t4_data3_kept", {28'b0, out_data3}, 32'hd);
    out_ready = 4'b1001;
    #1 check("t4_unstall", {31'b0, in_ready}, 32'd1);
    tick();
    out_ready = 4'b0000;
    check("t4_valid_a", {28'b0, out_valid}, 32'h8);
    check("t4_data3", {28'b0, out_data3}, 32'h6);
    in_data = 4'h9; in_sel = 2'd0;
    #1 check("t4_ready0", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("t4_valid_b", {28'b0, out_valid}, 32'h9);
    check("t4_data0", {28'b0, out_data0}, 32'h9);

    // Reset with channels 0 and 2 full and a word on offer.
    in_valid = 1'b1; in_data = 4'h1; in_sel = 2'd2;
    tick();
    in_valid = 1'b0;
    out_ready = 4'b1000;
    tick();
    out_ready = 4'b0000;
    check("t5_pre", {28'b0, out_valid}, 32'h5);
    rst = 1'b0; in_valid = 1'b1; in_data = 4'he; in_sel = 2'd1;
    #1 check("t5_rst_ready", {31'b0, in_ready}, 32'd0);
    tick();
    rst = 1'b1; in_valid = 1'b0;
    check("t5_valid", {28'b0, out_valid}, 32'h0);
    check("t5_data0", {28'b0, out_data0}, 32'h0);
    check("t5_data1", {28'b0, out_data1}, 32'h0);
    in_valid = 1'b1; in_data = 4'h4; in_sel = 2'd2;
    tick();
    in_valid = 1'b0;
    check("t5_after_valid", {28'b0, out_valid}, 32'h4);
    check("t5_after_data2", {28'b0, out_data2}, 32'h4);

    // Unknown data passes through unchanged, then is overwritten exactly.
    xval = 'x;
    in_valid = 1'b1; in_data = xval; in_sel = 2'd3;
    tick();
    in_valid = 1'b0;
    check("t6_valid", {28'b0, out_valid}, 32'hc);
    check("t6_xdata", {28'b0, out_data3}, {28'b0, xval});
    out_ready = 4'b1000;
    in_valid = 1'b1; in_data = 4'h7; in_sel = 2'd3;
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    check("t6_replace", {28'b0, out_data3}, 32'h7);
    check("t6_valid2", {28'b0, out_valid}, 32'hc);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
